// File: rtl/pack_check_pkg.sv
// rtl/pack_check_pkg.sv - shared types, constants and helpers for the egress packet checker
//
// Purpose: parser state encoding, frame layout constants, MAC derivation
//          and the packed metadata word used by pack_check.
// Contents: state_t, WORDS_PER_BLOCK, HDR_WORDS, PAYLOAD_WORD, MAC_BASE,
//           meta_t, mac_of_port().
package pack_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    TIME_HI,
    TIME_LO,
    SMAC_HI,
    SMAC_LO,
    PAYLOAD
  } state_t;

  localparam int          WORDS_PER_BLOCK = 8;
  localparam int          HDR_WORDS       = 6;
  localparam logic [31:0] PAYLOAD_WORD    = 32'hFFFF_FFFF;
  localparam logic [47:0] MAC_BASE        = 48'h0200_0000_0000;

  typedef struct packed {
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [11:0] length;
  } meta_t;

  // Port number lives in the two LSBs; the rest is the fixed base.
  function automatic logic [47:0] mac_of_port(input logic [1:0] port);
    return {MAC_BASE[47:2], port};
  endfunction

endpackage

// File: rtl/pack_check_if.sv
// rtl/pack_check_if.sv - ingress word stream into the packet checker
//
// Purpose: carries the fabric-side packet words; no backpressure.
// Signals: in_valid (word present this cycle), in_data[31:0] (packet word).
// Modports: master drives the stream, slave (the checker) consumes it.
interface pack_check_if;
  logic        in_valid;
  logic [31:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/pack_check_sat_cnt.sv
// rtl/pack_check_sat_cnt.sv - 16-bit counter that sticks at all-ones
//
// Purpose: event counter for good/errored packets.
// Ports: clk, reset (sync, active-high), i_inc (count this cycle),
//        o_cnt[15:0] (current count).
module sat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pack_check.sv
// rtl/pack_check.sv - egress packet checker: header parse, MAC/payload check, latency
//
// Purpose: parses the 32-bit packet stream, checks length, destination MAC
//          and payload, then reports {src, dst, length}, one-way latency
//          and error flags one cycle after the final word.
// Ports: clk, reset (sync, active-high), s_in (word stream, slave),
//        cur_time[63:0] (timestamp base), meta_valid (completion pulse),
//        meta_out (metadata), latency[31:0], err[2:0] {payload, mac, len},
//        pkt_cnt / err_cnt (saturating good / errored packet counts).
module pack_check
  import pack_pkg::*;
#(
  parameter int MY_PORT    = 0,
  parameter int META_WIDTH = 16,
  parameter int MAX_BLOCKS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  pack_check_if.slave           s_in,
  input  logic [63:0]           cur_time,
  output logic                  meta_valid,
  output logic [META_WIDTH-1:0] meta_out,
  output logic [31:0]           latency,
  output logic [2:0]            err,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_cnt
);

  localparam logic [47:0] MY_MAC  = mac_of_port(2'(MY_PORT));
  localparam logic [11:0] MAX_LEN = 12'(MAX_BLOCKS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_len;
  logic [8:0]  r_rem;
  logic        r_mac_err;
  logic        r_pay_err;
  logic [1:0]  r_dst;
  logic [1:0]  r_src;
  logic [31:0] r_ts;

  logic        r_meta_valid;
  meta_t       r_meta;
  logic [31:0] r_latency;
  logic [2:0]  r_err;

  logic [11:0] w_in_len;
  logic [8:0]  w_rem_init;
  logic [8:0]  w_rem_dec;
  logic        w_mac_bad;
  logic        w_pay_bad;
  logic        w_done;
  logic [2:0]  w_err;
  meta_t       w_meta;
  logic [31:0] w_lat;
  logic        w_unused;

  assign w_in_len  = s_in.in_data[27:16];
  // rem counts the words still to come after W0, so the final word is
  // the one accepted while rem is 1 (it decrements to 0).
  assign w_rem_init = 9'(w_in_len * 12'(WORDS_PER_BLOCK)) - 9'd1;
  assign w_rem_dec  = r_rem - 9'd1;
  assign w_unused   = ^cur_time[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HDR0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mac_bad   = 1'b0;
    w_pay_bad   = 1'b0;
    w_done      = 1'b0;
    w_err       = 3'b000;
    w_meta      = '0;
    w_lat       = '0;
    if (s_in.in_valid) begin
      case (r_state)
        HDR0: begin
          w_mac_bad = (s_in.in_data[15:0] != MY_MAC[47:32]);
          if ((w_in_len == 12'd0) || (w_in_len > MAX_LEN)) begin
            // No timestamp or ports were seen; only the length is reported.
            w_done        = 1'b1;
            w_err         = 3'b001;
            w_meta.length = w_in_len;
          end else begin
            w_state_nxt = HDR1;
          end
        end
        HDR1:    begin
          w_mac_bad   = (s_in.in_data != MY_MAC[31:0]);
          w_state_nxt = TIME_HI;
        end
        TIME_HI: w_state_nxt = TIME_LO;
        TIME_LO: w_state_nxt = SMAC_HI;
        SMAC_HI: w_state_nxt = SMAC_LO;
        SMAC_LO: w_state_nxt = PAYLOAD;
        PAYLOAD: begin
          w_pay_bad = (s_in.in_data != PAYLOAD_WORD);
          if (w_rem_dec == 9'd0) begin
            w_done      = 1'b1;
            w_err       = {r_pay_err | w_pay_bad, r_mac_err, 1'b0};
            w_meta.src    = r_src;
            w_meta.dst    = r_dst;
            w_meta.length = r_len;
            w_lat       = cur_time[31:0] - r_ts;
            w_state_nxt = HDR0;
          end
        end
        default: w_state_nxt = HDR0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len     <= '0;
      r_rem     <= '0;
      r_mac_err <= 1'b0;
      r_pay_err <= 1'b0;
      r_dst     <= '0;
      r_src     <= '0;
      r_ts      <= '0;
    end else if (s_in.in_valid) begin
      r_rem <= (r_state == HDR0) ? w_rem_init : w_rem_dec;
      case (r_state)
        HDR0: begin
          r_len     <= w_in_len;
          r_mac_err <= w_mac_bad;
          r_pay_err <= 1'b0;
        end
        HDR1: begin
          r_mac_err <= r_mac_err | w_mac_bad;
          r_dst     <= s_in.in_data[1:0];
        end
        TIME_LO: r_ts      <= s_in.in_data;
        SMAC_LO: r_src     <= s_in.in_data[17:16];
        PAYLOAD: r_pay_err <= r_pay_err | w_pay_bad;
        default: ;
      endcase
    end
  end

  // Result registers hold until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta_valid <= 1'b0;
      r_meta       <= '0;
      r_latency    <= '0;
      r_err        <= '0;
    end else begin
      r_meta_valid <= w_done;
      if (w_done) begin
        r_meta    <= w_meta;
        r_latency <= w_lat;
        r_err     <= w_err;
      end
    end
  end

  sat_cnt u_pkt_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_done && (w_err == 3'b000)),
    .o_cnt (pkt_cnt)
  );

  sat_cnt u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_done && (w_err != 3'b000)),
    .o_cnt (err_cnt)
  );

  assign meta_valid = r_meta_valid;
  assign meta_out   = r_meta;
  assign latency    = r_latency;
  assign err        = r_err;

endmodule

// File: tb/tb_pack_check.sv
// tb/tb_pack_check.sv - randomized self-checking bench for pack_check (ports 0 and 3)
module tb_pack_check;
  import pack_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] cur_time;

  always #5 clk = ~clk;

  pack_check_if u_if ();

  logic        mv [2];
  logic [15:0] mo [2];
  logic [31:0] lat[2];
  logic [2:0]  er [2];
  logic [15:0] pc [2];
  logic [15:0] ec [2];

  pack_check #(.MY_PORT(0), .META_WIDTH(16), .MAX_BLOCKS(64)) u_dut0 (
    .clk(clk), .reset(reset), .s_in(u_if), .cur_time(cur_time),
    .meta_valid(mv[0]), .meta_out(mo[0]), .latency(lat[0]), .err(er[0]),
    .pkt_cnt(pc[0]), .err_cnt(ec[0])
  );

  pack_check #(.MY_PORT(3), .META_WIDTH(16), .MAX_BLOCKS(64)) u_dut3 (
    .clk(clk), .reset(reset), .s_in(u_if), .cur_time(cur_time),
    .meta_valid(mv[1]), .meta_out(mo[1]), .latency(lat[1]), .err(er[1]),
    .pkt_cnt(pc[1]), .err_cnt(ec[1])
  );

  typedef struct {
    int unsigned due;
    logic        len_bad;
    logic        up_bad;
    logic        pay_bad;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [11:0] length;
    logic [31:0] lat;
  } exp_t;

  exp_t        pend[$];
  int unsigned cyc;
  int          n_total;
  int          n_bad;
  int          good_m[2];
  int          bad_m[2];

  function automatic logic [1:0] port_of(input int k);
    return (k == 0) ? 2'd0 : 2'd3;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic       due;
    exp_t       e;
    logic [2:0] xe;
    due = (pend.size() > 0) && (pend[0].due == cyc);
    if (due) e = pend[0];
    for (int k = 0; k < 2; k++) begin
      if (mv[k] || due) begin
        check_eq($sformatf("pulse_p%0d", port_of(k)), mv[k], due);
        if (due) begin
          if (e.len_bad) begin
            xe = 3'b001;
            check_eq($sformatf("len_field_p%0d", port_of(k)), mo[k][11:0], e.length);
          end else begin
            xe = {e.pay_bad, e.up_bad || (e.dst != port_of(k)), 1'b0};
            check_eq($sformatf("meta_p%0d", port_of(k)), mo[k], {e.src, e.dst, e.length});
            check_eq($sformatf("lat_p%0d", port_of(k)), lat[k], e.lat);
          end
          check_eq($sformatf("err_p%0d", port_of(k)), er[k], xe);
          if (xe == 3'b000) good_m[k] = (good_m[k] >= 65535) ? 65535 : good_m[k] + 1;
          else              bad_m[k]  = (bad_m[k]  >= 65535) ? 65535 : bad_m[k] + 1;
          check_eq($sformatf("pkt_cnt_p%0d", port_of(k)), pc[k], good_m[k]);
          check_eq($sformatf("err_cnt_p%0d", port_of(k)), ec[k], bad_m[k]);
        end
      end
    end
    if (due) void'(pend.pop_front());
  endtask

  // One clock: sample on the falling edge, then default the stream to idle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check_outputs();
    cur_time = cur_time + 64'd1;
    u_if.in_valid = 1'b0;
    u_if.in_data  = $urandom();
  endtask

  task automatic send_pkt(input logic [11:0] len, input logic [1:0] src, input logic [1:0] dst,
                          input logic [45:0] up_flip, input logic [63:0] ts, input int bad_idx,
                          input int bad_bit, input int gap_pct, input int stop_at);
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [31:0] w;
    logic        lbad;
    int          nw;
    exp_t        e;
    dmac = {MAC_BASE[47:2] ^ up_flip, dst};
    smac = {16'($urandom()), $urandom()};
    smac[1:0] = src;
    lbad = (len == 12'd0) || (len > 12'd64);
    nw = lbad ? 1 : int'(len) * 8;
    for (int i = 0; i < nw; i++) begin
      if (i == stop_at) return;
      while ((gap_pct > 0) && ($urandom_range(99) < gap_pct)) tick();
      tick();
      case (i)
        0:       w = {4'h0, len, dmac[47:32]};
        1:       w = dmac[31:0];
        2:       w = ts[63:32];
        3:       w = ts[31:0];
        4:       w = smac[47:16];
        5:       w = {smac[15:0], 16'($urandom())};
        default: w = (i == bad_idx) ? ~(32'd1 << bad_bit) : 32'hFFFF_FFFF;
      endcase
      u_if.in_valid = 1'b1;
      u_if.in_data  = w;
      if (i == nw - 1) begin
        e.due     = cyc + 1;
        e.len_bad = lbad;
        e.up_bad  = (up_flip != '0);
        e.pay_bad = (bad_idx >= HDR_WORDS) && (bad_idx < nw);
        e.src     = src;
        e.dst     = dst;
        e.length  = len;
        e.lat     = cur_time[31:0] - ts[31:0];
        pend.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pend.delete();
    good_m = '{0, 0};
    bad_m  = '{0, 0};
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_valid"}, mv[k], 1'b0);
      check_eq({tag, "_meta"}, mo[k], 16'h0);
      check_eq({tag, "_lat"}, lat[k], 32'h0);
      check_eq({tag, "_err"}, er[k], 3'h0);
      check_eq({tag, "_pkt"}, pc[k], 16'h0);
      check_eq({tag, "_errc"}, ec[k], 16'h0);
    end
  endtask

  initial begin
    logic [11:0] rl;
    logic [45:0] rf;
    int          bi;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    cur_time = 64'd0;
    reset   = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
    do_reset();
    tick();
    check_zero("reset");

    // Minimum packet, src 2 to port 3: last word sampled with cur_time 175.
    cur_time = 64'd167;
    send_pkt(12'd1, 2'd2, 2'd3, '0, 64'd100, -1, 0, 0, -1);
    tick();
    check_eq("min_meta", mo[1], 16'hB001);
    check_eq("min_lat", lat[1], 32'd75);
    check_eq("min_err", er[1], 3'b000);
    check_eq("min_pkt_cnt", pc[1], 16'd1);

    // Maximum packet with random idle gaps.
    send_pkt(12'd64, 2'd1, 2'd0, '0, {$urandom(), $urandom()}, -1, 0, 30, -1);
    tick();

    // Payload word 3 corrupted, then a clean back-to-back packet.
    send_pkt(12'd2, 2'd3, 2'd0, '0, 64'd5000, HDR_WORDS + 3, 0, 0, -1);
    send_pkt(12'd2, 2'd3, 2'd0, '0, 64'd6000, -1, 0, 0, -1);

    // Wrong destination port, then a correctly addressed packet.
    send_pkt(12'd3, 2'd0, 2'd1, '0, 64'd7000, -1, 0, 10, -1);
    send_pkt(12'd1, 2'd2, 2'd0, '0, 64'd8000, -1, 0, 0, -1);

    // Length 0 and 65, then a header parsed normally.
    send_pkt(12'd0, 2'd0, 2'd0, '0, 64'd0, -1, 0, 0, -1);
    send_pkt(12'd65, 2'd0, 2'd0, '0, 64'd0, -1, 0, 0, -1);
    send_pkt(12'd1, 2'd1, 2'd3, '0, 64'hFFFF_FFFF_FFFF_FF00, -1, 0, 0, -1);
    tick();

    // Reset while inside word 20 of a length-4 packet.
    send_pkt(12'd4, 2'd1, 2'd0, '0, 64'd9000, -1, 0, 0, 20);
    do_reset();
    tick();
    check_zero("midrst");
    send_pkt(12'd2, 2'd1, 2'd0, '0, 64'd100, -1, 0, 0, -1);
    tick();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(9))
        0:       rl = ($urandom_range(1) == 0) ? 12'd0 : 12'($urandom_range(4095, 65));
        1:       rl = 12'd64;
        default: rl = 12'($urandom_range(16, 1));
      endcase
      rf = ($urandom_range(7) == 0) ? (46'd1 << $urandom_range(45)) : '0;
      bi = ($urandom_range(5) == 0) ? int'($urandom_range(int'(rl) * 8 + 1, HDR_WORDS)) : -1;
      send_pkt(rl, 2'($urandom()), 2'($urandom()), rf, {$urandom(), $urandom()},
               bi, int'($urandom_range(31)), int'($urandom_range(50)), -1);
      if ($urandom_range(1) == 0) repeat ($urandom_range(3)) tick();
    end

    repeat (4) tick();
    check_eq("drain", pend.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
